// File: rtl/benes_cfg_loader_if.sv
// benes_cfg_loader_if: config handshake and live switch bus between source, loader and network
interface benes_cfg_loader_if #(
  parameter int N_STAGE = 7,
  parameter int N_SW    = 8
);
  logic                         cfg_valid;
  logic                         cfg_ready;
  logic [N_STAGE-1:0][N_SW-1:0] cfg_set;
  logic [N_STAGE-1:0][N_SW-1:0] switch_set;
  logic                         apply_start;
  logic                         apply_done;
  logic                         busy;
  modport master (
    output cfg_valid, cfg_set,
    input  cfg_ready, switch_set, apply_start, apply_done, busy
  );
  modport slave (
    input  cfg_valid, cfg_set,
    output cfg_ready, switch_set, apply_start, apply_done, busy
  );
endinterface

// File: rtl/benes_cfg_loader.sv
// benes_cfg_loader: applies a Benes switch configuration to the network as a per-stage skewed wavefront
module benes_cfg_loader #(
  parameter int N_STAGE   = 7,
  parameter int N_SW      = 8,
  parameter int STAGE_LAT = 2
) (
  input logic               clk,
  input logic               rst,
  benes_cfg_loader_if.slave bus
);
  localparam int LAST_I = (N_STAGE - 1) * STAGE_LAT;
  localparam int CW = LAST_I > 0 ? $clog2(LAST_I + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(LAST_I);
  typedef enum logic {IDLE, SKEW} state_t;
  state_t                       r_state, w_next;
  logic [CW-1:0]                r_cnt;
  logic [N_STAGE-1:0][N_SW-1:0] r_shadow, r_sw;
  logic                         r_start, r_done;
  logic                         w_accept, w_last;
  always_comb begin
    w_accept = r_state == IDLE && bus.cfg_valid;
    w_last   = r_state == SKEW && r_cnt == LAST;
    w_next   = r_state == IDLE ? ((w_accept && N_STAGE > 1) ? SKEW : IDLE)
                               : (w_last ? IDLE : SKEW);
  end
  always_ff @(posedge clk)
    r_state <= rst ? IDLE : w_next;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_shadow <= '0;
      r_sw     <= '0;
      r_start  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_cnt   <= w_next == SKEW ? r_cnt + CW'(1) : '0;
      r_start <= w_accept;
      r_done  <= w_last || (w_accept && N_STAGE == 1);
      if (w_accept) begin
        r_shadow <= bus.cfg_set;
        r_sw[0]  <= bus.cfg_set[0];
      end
      for (int k = 1; k < N_STAGE; k++)
        if (r_state == SKEW && r_cnt == CW'(k * STAGE_LAT))
          r_sw[k] <= r_shadow[k];
    end
  end
  assign bus.cfg_ready   = !rst && r_state == IDLE;
  assign bus.busy        = r_state == SKEW;
  assign bus.switch_set  = r_sw;
  assign bus.apply_start = r_start;
  assign bus.apply_done  = r_done;
endmodule

// File: doc/benes_cfg_loader.md
# benes_cfg_loader

Drives the per-stage `switch_set` bus of the 16×16 pipelined Benes network.

- Accepts a complete 7-stage switch configuration through a valid/ready handshake.
- Applies it to the network as a skewed wavefront: stage k changes k·STAGE_LAT cycles after stage 0, so data entering right after the apply start traverses every stage under the new configuration.
- Sits between the software-facing configuration source and the network's `switch_set` input.

## Interface
- `N_STAGE`, default 7: number of switch stages.
- `N_SW`, default 8: 2×2 switches per stage, one control bit each.
- `STAGE_LAT`, default 2: cycles between consecutive stage inputs of the network (stage register plus inter-stage register). Legal range is 1 or more.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cfg_valid`  in  1  `cfg_set` holds a new configuration.
- `cfg_ready`  out  1  loader can accept a configuration.
- `cfg_set`  in  [N_SW-1:0] × [N_STAGE-1:0]  requested configuration, `cfg_set[k]` for stage k.
- `switch_set`  out  [N_SW-1:0] × [N_STAGE-1:0]  live per-stage control bits to the network.
- `apply_start`  out  1  one-cycle pulse: stage 0 is now on the new configuration.
- `apply_done`  out  1  one-cycle pulse: the last stage is now on the new configuration.
- `busy`  out  1  a wavefront is in flight; equals `!cfg_ready` outside reset.

## Operation
- Accept occurs on a rising edge where `cfg_valid && cfg_ready`. `cfg_set` is captured into a shadow register at that edge. Later changes on `cfg_set` are ignored.
- State machine:
  - IDLE: `cfg_ready` = 1, skew counter = 0, `switch_set` held. On accept: `switch_set[0]` ← `cfg_set[0]`, shadow ← `cfg_set`, counter ← 1, go to SKEW.
  - SKEW: `cfg_ready` = 0. Counter increments every cycle. When the counter equals k·STAGE_LAT (k = 1..N_STAGE-1), `switch_set[k]` ← `shadow[k]` on that edge. On the edge that loads stage N_STAGE-1, return to IDLE and clear the counter.
- Counter width is `$clog2((N_STAGE-1)*STAGE_LAT+1)`. No wrap-around is possible because the counter is cleared on exit.
- Each `switch_set[k]` is written exactly once per configuration. Stages not yet reached keep the previous configuration bit-exactly.
- A `cfg_valid` asserted during SKEW is not accepted. The source must hold it until `cfg_ready` is high. Deasserting `cfg_valid` before acceptance is legal.
- Reset values:
  - `switch_set` = all zeros.
  - `cfg_ready` = 0 while `rst` is high, 1 in the first cycle after `rst` deasserts.
  - `apply_start`, `apply_done`, `busy` = 0.
  - Shadow = 0, state = IDLE.
- Reset mid-SKEW aborts the wavefront: every stage returns to zero on the reset edge, with no `apply_done` pulse and no partial configuration retained.

## Timing
- Accept edge E. Stage k updates at edge E + k·STAGE_LAT. With defaults, stages update at E, E+2, E+4, E+6, E+8, E+10, E+12.
- `apply_start` is high for exactly the cycle after E.
- `apply_done` is high for exactly the cycle after edge E + (N_STAGE-1)·STAGE_LAT. `cfg_ready` is high in that same cycle.
- Minimum accept-to-accept spacing is (N_STAGE-1)·STAGE_LAT + 1 cycles, i.e. 13 with defaults.
- Outputs are registered. There is no combinational path from `cfg_valid` or `cfg_set` to any output.
- With N_STAGE = 1, the accept edge itself returns to IDLE, and `apply_start` and `apply_done` pulse in the same cycle.

## Test plan
- **Reset:** hold `rst` for 3 cycles with `cfg_valid` = 1 → `switch_set` all 0x00, `cfg_ready` = 0 during reset, 1 in the first cycle after reset; no accept occurs during reset.
- **Single apply, defaults:** `cfg_set[k]` = 0x11·(k+1), accepted at edge E → `switch_set[0]` = 0x11 after E, `switch_set[3]` = 0x44 after E+6, `switch_set[6]` = 0x77 after E+12; `apply_start` pulses the cycle after E, `apply_done` the cycle after E+12.
- **Skew ordering:** set all stages to 0xFF, then accept all 0x00 → between edges E+4 and E+6, `switch_set[0..2]` = 0x00 and `switch_set[3..6]` = 0xFF.
- **Back-to-back:** `cfg_valid` held high with config A then B → B is accepted exactly 13 cycles after A; changing `cfg_set` mid-SKEW does not alter any stage of A.
- **Reset mid-wavefront:** assert `rst` at E+5 → all stages 0x00 on the next edge, no `apply_done`, `cfg_ready` = 1 the cycle after `rst` drops.
- **Parameter sweep:** STAGE_LAT = 1 and N_STAGE = 1 → updates spaced by 1 cycle; with N_STAGE = 1, `apply_start` and `apply_done` coincide.
